register_file: RTL and testbench
================================

# register_file

Multi-port register file that sources the operand buses for the ALU: its two read ports drive the `X`/`Y` inputs of the downstream 2:1 operand muxes (`mux_2to1 #(.N(32))`). It holds `2**A` registers of `N` bits with two registered read ports and one synchronous write port. Register 0 is hardwired to zero. An optional write-through bypass resolves same-cycle read/write hazards.

## Interface
Parameters:
- `N`, 32, data width of every register and data port
- `A`, 5, address width; depth = `2**A` registers

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `rst`  input  1  asynchronous, active-high reset
- `rd_addr0`  input  A  read port 0 address
- `rd_addr1`  input  A  read port 1 address
- `rd_data0`  output  N  registered read data, port 0 (feeds operand mux `X`)
- `rd_data1`  output  N  registered read data, port 1 (feeds operand mux `Y`)
- `wr_ena`  input  1  write enable
- `wr_addr`  input  A  write address
- `wr_data`  input  N  write data

## Operation
- Storage: array `regs[0 .. 2**A-1]`, each `N` bits.
- Write: on a rising edge with `wr_ena=1` and `wr_addr!=0`, `regs[wr_addr] <= wr_data`. Writes to address 0 are discarded silently. `regs[0]` always reads 0.
- Read: on every rising edge, `rd_dataK <= regs[rd_addrK]` for K=0,1. The value read is the array contents *before* that edge's write, unless the bypass applies (see Configuration).
- Both read ports are independent. Both may address the same register, and both return identical data.
- A read of address 0 always returns 0, with or without the bypass, even when `wr_ena=1` and `wr_addr=0`.
- Reset: asserting `rst` immediately (asynchronously) clears every `regs[i]`, `rd_data0`, and `rd_data1` to 0. These stay at 0 while `rst` is high, and all writes are ignored during reset.
- Reset mid-operation: a write on the same edge that `rst` rises is lost. The first write after reset takes effect on the first rising edge with `rst` low.
- No X-propagation: outputs are never undefined after reset.

## Timing
- Read latency: 1 cycle. An address presented before edge k appears on `rd_dataK` after edge k and holds until edge k+1.
- Write latency: 1 cycle. Data written at edge k is visible to a read sampled at edge k+1. It appears on `rd_data` after edge k+1, or after edge k when the bypass is active.
- Throughput: one write and two reads per cycle, with no stalls.
- `rd_data0`/`rd_data1` are direct flop outputs with no combinational path from any input, so the downstream mux sees stable operands for a full cycle.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- When defined, the bypass is enabled. On an edge where `wr_ena=1`, `wr_addr!=0`, and `wr_addr==rd_addrK`, `rd_dataK` captures `wr_data` instead of the stale `regs[rd_addrK]`. This applies to each port independently.
- When undefined, `rd_dataK` captures the old register contents on a same-address collision. The new value is seen one cycle later.
- The array write behaviour is identical in both builds.

## Test plan
- Reset: preload `regs[3]=0xDEADBEEF`, assert `rst` between edges. Required: `rd_data0`, `rd_data1`, and all registers read 0 immediately and on subsequent reads of addresses 0..31.
- Write/read: write `0x00000001` to r1 and `2**31` to r2 on consecutive edges. Then read r1 on port 0 and r2 on port 1. Required: `rd_data0=0x00000001` and `rd_data1=0x80000000` one cycle after the addresses are applied.
- Zero register: write `0xFFFFFFFF` to r0, then read r0 on both ports. Required: both read 0. Also write r0 and read r0 on the same edge: result is 0 in both builds.
- Collision: r5 holds `0x11111111`. On one edge, write `0x22222222` to r5 while `rd_addr0=rd_addr1=5`. Required: both ports read `0x22222222` if `REGFILE_BYPASS_EN` is defined, otherwise `0x11111111`. In both builds, the next cycle reads `0x22222222`.
- Write disable: set `wr_ena=0` with `wr_addr=7` and `wr_data=0xABCD0000`. Required: r7 keeps its prior value (0 after reset).
- Sweep: write `i*0x01010101` to ri for i=1..31, then read all registers pairwise. Required: every register reads back its value, with zero errors reported.

Source files
------------

// File: rtl/register_file.sv
// register_file: 2**A x N register file with two registered read ports and one
// synchronous write port. Register 0 is hardwired to zero.
// Optional write-through bypass: define REGFILE_BYPASS_EN so that a read that
// collides with a same-edge write to the same (nonzero) address captures the
// new write data instead of the stale array contents.
module register_file #(
    parameter int unsigned N = 32,
    parameter int unsigned A = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [A-1:0] rd_addr0,
    input  logic [A-1:0] rd_addr1,
    output logic [N-1:0] rd_data0,
    output logic [N-1:0] rd_data1,
    input  logic         wr_ena,
    input  logic [A-1:0] wr_addr,
    input  logic [N-1:0] wr_data
);

    localparam int unsigned DEPTH = 2 ** A;

    logic [N-1:0] regs [DEPTH];
    logic         wr_live;
    logic [N-1:0] rd_next0;
    logic [N-1:0] rd_next1;

    // A write only lands when enabled and not aimed at the zero register
    assign wr_live = wr_ena && (wr_addr != '0);

    // Storage array: cleared asynchronously, entry 0 never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[A'(i)] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Next read values: array lookup, optional bypass, address 0 forced to zero
    always_comb begin
        rd_next0 = regs[rd_addr0];
        rd_next1 = regs[rd_addr1];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (wr_addr == rd_addr0)) begin
            rd_next0 = wr_data;
        end
        if (wr_live && (wr_addr == rd_addr1)) begin
            rd_next1 = wr_data;
        end
`endif
        if (rd_addr0 == '0) begin
            rd_next0 = '0;
        end
        if (rd_addr1 == '0) begin
            rd_next1 = '0;
        end
    end

    // Read data flops: outputs carry no combinational path from inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data0 <= '0;
            rd_data1 <= '0;
        end else begin
            rd_data0 <= rd_next0;
            rd_data1 <= rd_next1;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_register_file;

    localparam int unsigned N     = 32;
    localparam int unsigned A     = 5;
    localparam int unsigned DEPTH = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [A-1:0] rd_addr0 = '0;
    logic [A-1:0] rd_addr1 = '0;
    logic [N-1:0] rd_data0;
    logic [N-1:0] rd_data1;
    logic         wr_ena = 1'b0;
    logic [A-1:0] wr_addr = '0;
    logic [N-1:0] wr_data = '0;

    logic [N-1:0] model [DEPTH];
    logic [N-1:0] exp0;
    logic [N-1:0] exp1;
    int checks = 0;
    int errors = 0;

    register_file #(.N(N), .A(A)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    // Value a read port should capture on an edge, from the architectural rules
    function automatic logic [N-1:0] predict(input logic [A-1:0] ra, input logic we,
                                             input logic [A-1:0] wa, input logic [N-1:0] wd);
        if (ra == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && (wa != '0) && (wa == ra)) return wd;
`endif
        return model[ra];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    // Apply one cycle of inputs, set exp0/exp1, advance past the edge, update model
    task automatic drive_cycle(input logic [A-1:0] ra0, input logic [A-1:0] ra1,
                               input logic we, input logic [A-1:0] wa,
                               input logic [N-1:0] wd);
        rd_addr0 = ra0;
        rd_addr1 = ra1;
        wr_ena   = we;
        wr_addr  = wa;
        wr_data  = wd;
        exp0 = predict(ra0, we, wa, wd);
        exp1 = predict(ra1, we, wa, wd);
        @(posedge clk);
        #1;
        if (we && (wa != '0)) model[wa] = wd;
        wr_ena = 1'b0;
    endtask

    task automatic test_reset();
        drive_cycle(5'd0, 5'd0, 1'b1, 5'd3, 32'hDEADBEEF);
        drive_cycle(5'd3, 5'd3, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rd_data0 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL preload_r3: got %h expected %h", rd_data0, 32'hDEADBEEF);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            errors++;
            $display("FAIL reset_async: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
        // a write while reset is high must be lost
        rd_addr0 = 5'd3;
        rd_addr1 = 5'd4;
        wr_ena   = 1'b1;
        wr_addr  = 5'd4;
        wr_data  = 32'h12345678;
        @(posedge clk);
        #1;
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
        wr_ena = 1'b0;
        rst    = 1'b0;
        clear_model();
        for (int i = 0; i < int'(DEPTH); i += 2) begin
            drive_cycle(A'(i), A'(i + 1), 1'b0, 5'd0, 32'h0);
            checks++;
            if (rd_data0 !== '0 || rd_data1 !== '0) begin
                errors++;
                $display("FAIL reset_sweep r%0d/r%0d: got %h/%h expected 0/0",
                         i, i + 1, rd_data0, rd_data1);
            end
        end
    endtask

    task automatic test_write_read();
        drive_cycle(5'd0, 5'd0, 1'b1, 5'd1, 32'h00000001);
        drive_cycle(5'd0, 5'd0, 1'b1, 5'd2, 32'h80000000);
        drive_cycle(5'd1, 5'd2, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rd_data0 !== 32'h00000001 || rd_data1 !== 32'h80000000) begin
            errors++;
            $display("FAIL write_read: got %h/%h expected 00000001/80000000",
                     rd_data0, rd_data1);
        end
    endtask

    task automatic test_zero_reg();
        drive_cycle(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        drive_cycle(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            errors++;
            $display("FAIL zero_reg: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
        drive_cycle(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            errors++;
            $display("FAIL zero_reg_same_edge: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
    endtask

    task automatic test_collision();
        logic [N-1:0] want;
`ifdef REGFILE_BYPASS_EN
        want = 32'h22222222;
`else
        want = 32'h11111111;
`endif
        drive_cycle(5'd0, 5'd0, 1'b1, 5'd5, 32'h11111111);
        drive_cycle(5'd5, 5'd5, 1'b1, 5'd5, 32'h22222222);
        checks++;
        if (rd_data0 !== want || rd_data1 !== want) begin
            errors++;
            $display("FAIL collision: got %h/%h expected %h", rd_data0, rd_data1, want);
        end
        drive_cycle(5'd5, 5'd5, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rd_data0 !== 32'h22222222 || rd_data1 !== 32'h22222222) begin
            errors++;
            $display("FAIL collision_next: got %h/%h expected 22222222",
                     rd_data0, rd_data1);
        end
    endtask

    task automatic test_write_disable();
        drive_cycle(5'd0, 5'd0, 1'b0, 5'd7, 32'hABCD0000);
        drive_cycle(5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            errors++;
            $display("FAIL write_disable: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
    endtask

    task automatic test_sweep();
        logic [N-1:0] v0;
        logic [N-1:0] v1;
        for (int i = 1; i < int'(DEPTH); i++) begin
            drive_cycle(5'd0, 5'd0, 1'b1, A'(i), N'(i) * 32'h01010101);
        end
        for (int i = 0; i < int'(DEPTH); i += 2) begin
            drive_cycle(A'(i), A'(i + 1), 1'b0, 5'd0, 32'h0);
            v0 = N'(i) * 32'h01010101;
            v1 = N'(i + 1) * 32'h01010101;
            checks++;
            if (rd_data0 !== v0 || rd_data1 !== v1) begin
                errors++;
                $display("FAIL sweep r%0d/r%0d: got %h/%h expected %h/%h",
                         i, i + 1, rd_data0, rd_data1, v0, v1);
            end
        end
    endtask

    task automatic test_random();
        logic [A-1:0] ra0;
        logic [A-1:0] ra1;
        logic [A-1:0] wa;
        for (int k = 0; k < 300; k++) begin
            // bias half the traffic onto a few registers to provoke collisions
            if ($urandom_range(0, 1) == 0) begin
                ra0 = A'($urandom_range(0, 3));
                ra1 = A'($urandom_range(0, 3));
                wa  = A'($urandom_range(0, 3));
            end else begin
                ra0 = A'($urandom_range(0, 31));
                ra1 = A'($urandom_range(0, 31));
                wa  = A'($urandom_range(0, 31));
            end
            drive_cycle(ra0, ra1, 1'($urandom_range(0, 1)), wa, N'($urandom));
            checks++;
            if (rd_data0 !== exp0 || rd_data1 !== exp1) begin
                errors++;
                $display("FAIL random[%0d] ra=%0d/%0d: got %h/%h expected %h/%h",
                         k, ra0, ra1, rd_data0, rd_data1, exp0, exp1);
            end
        end
    endtask

    initial begin
        clear_model();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rd_data0 !== '0 || rd_data1 !== '0) begin
            errors++;
            $display("FAIL power_on_reset: got %h/%h expected 0/0", rd_data0, rd_data1);
        end
        #5 rst = 1'b0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_collision();
        test_write_disable();
        test_sweep();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
